// File: rtl/knn_local_sp_pkg.sv
// Shared constants and types for the kNN local search-space buffer arbiter.
package knn_local_sp_pkg;

    localparam int KNN_DATA_W     = 256;
    localparam int KNN_ADDR_W     = 11;
    localparam int KNN_RD_LATENCY = 1;
    localparam int KNN_RSP_DEPTH  = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_t;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/knn_local_sp_rsp_fifo.sv
// Show-ahead, register-based response FIFO; head data is visible while o_valid is high.
module knn_local_sp_rsp_fifo
    import knn_local_sp_pkg::*;
#(
    parameter  int WIDTH = KNN_DATA_W,
    parameter  int DEPTH = KNN_RSP_DEPTH,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push_ok = i_push & ~w_full;
    assign w_pop_ok  = i_pop & ~w_empty;

    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; contents need no reset because occupancy is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Upstream credit accounting must never let a push land on a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(i_push && w_full));
        end
    end

endmodule

// File: rtl/knn_local_sp_arbiter.sv
// Arbitrates one single-port search-space buffer between the load stage (writes)
// and the distance stage (reads); read data returns in order through a credited FIFO.
module knn_local_sp_arbiter
    import knn_local_sp_pkg::*;
#(
    parameter int DATA_W     = KNN_DATA_W,
    parameter int ADDR_W     = KNN_ADDR_W,
    parameter int RD_LATENCY = KNN_RD_LATENCY,
    parameter int RSP_DEPTH  = KNN_RSP_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_valid,
    output logic              o_rd_ready,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [ADDR_W-1:0] o_mem_address0,
    output logic              o_mem_ce0,
    output logic              o_mem_we0,
    output logic [DATA_W-1:0] o_mem_d0,
    input  logic [DATA_W-1:0] i_mem_q0,
    output logic              o_busy
);

    localparam int CNT_W = cnt_width(RSP_DEPTH);
    localparam int OCC_W = cnt_width(RSP_DEPTH + RD_LATENCY) + 1;

    grant_t              r_last_grant;
    grant_t              w_grant;
    logic [RD_LATENCY-1:0] r_inflight;
    logic [OCC_W-1:0]    w_inflight_cnt;
    logic [OCC_W-1:0]    w_occupancy;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_fifo_valid;
    logic [DATA_W-1:0]   w_fifo_data;
    logic                w_rd_eligible;
    logic                w_wr_req;
    logic                w_rd_req;
    logic                w_grant_wr;
    logic                w_grant_rd;
    logic                w_push;
    logic                w_pop;

    // Count reads currently travelling through the memory pipeline.
    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight_cnt = w_inflight_cnt + OCC_W'(r_inflight[i]);
        end
    end

    // Every in-flight read already owns a FIFO slot, so a push can never hit a full FIFO.
    assign w_occupancy   = w_inflight_cnt + OCC_W'(w_fifo_count);
    assign w_rd_eligible = (w_occupancy < OCC_W'(RSP_DEPTH));

    // Requests are masked while reset is held so nothing reaches the memory.
    assign w_wr_req = i_reset & i_wr_valid;
    assign w_rd_req = i_reset & i_rd_valid & w_rd_eligible;

    // Single-grant arbitration; a conflict goes to whichever side was not granted last.
    always_comb begin
        w_grant = GNT_NONE;
        if (w_wr_req && w_rd_req) begin
            w_grant = (r_last_grant == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (w_wr_req) begin
            w_grant = GNT_WR;
        end else if (w_rd_req) begin
            w_grant = GNT_RD;
        end
    end

    assign w_grant_wr = (w_grant == GNT_WR);
    assign w_grant_rd = (w_grant == GNT_RD);

    // Remember the last winner; READ after reset makes the first conflict go to WRITE.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_last_grant <= GNT_RD;
        end else if (w_grant != GNT_NONE) begin
            r_last_grant <= w_grant;
        end
    end

    // Valid shift register that mirrors the fixed memory read latency.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_inflight <= '0;
        end else begin
            r_inflight[0] <= w_grant_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_inflight[i] <= r_inflight[i-1];
            end
        end
    end

    assign w_push = r_inflight[RD_LATENCY-1];
    assign w_pop  = o_rsp_valid & i_rsp_ready;

    knn_local_sp_rsp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_push  (w_push),
        .i_data  (i_mem_q0),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count)
    );

    assign o_wr_ready     = w_grant_wr;
    assign o_rd_ready     = w_grant_rd;
    assign o_mem_ce0      = w_grant_wr | w_grant_rd;
    assign o_mem_we0      = w_grant_wr;
    assign o_mem_address0 = w_grant_rd ? i_rd_addr : (w_grant_wr ? i_wr_addr : '0);
    assign o_mem_d0       = w_grant_wr ? i_wr_data : '0;

    assign o_rsp_valid = i_reset & w_fifo_valid;
    assign o_rsp_data  = w_fifo_data;
    assign o_busy      = i_reset & ((w_inflight_cnt != '0) | (w_fifo_count != '0));

endmodule

// File: tb/tb_knn_local_sp_arbiter.sv
// Scoreboard bench: stimulus pushes expected read data on each read handshake,
// a forked monitor pops and compares whenever a response is consumed.
module tb_knn_local_sp_arbiter;

    localparam int DW      = 256;
    localparam int AW      = 11;
    localparam int RD_LAT  = 1;
    localparam int DEPTH   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] mem_address0;
    logic          mem_ce0;
    logic          mem_we0;
    logic [DW-1:0] mem_d0;
    logic [DW-1:0] mem_q0;
    logic          busy;

    logic [DW-1:0] mem_model [2048];
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int first_rsp_cyc = -1;
    bit lat_armed = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External single-port memory with one cycle read latency.
    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_we0) mem_model[mem_address0] <= mem_d0;
            else         mem_q0 <= mem_model[mem_address0];
        end
    end

    knn_local_sp_arbiter dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_rd_valid     (rd_valid),
        .o_rd_ready     (rd_ready),
        .i_rd_addr      (rd_addr),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_mem_address0 (mem_address0),
        .o_mem_ce0      (mem_ce0),
        .o_mem_we0      (mem_we0),
        .o_mem_d0       (mem_d0),
        .i_mem_q0       (mem_q0),
        .o_busy         (busy)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    task automatic run_monitor();
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (lat_armed && rsp_valid) begin
                first_rsp_cyc = cyc;
                lat_armed = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got %0h expected no response", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e);
                end
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_queue_left"}, DW'(exp_q.size()), '0);
        check({name, "_busy"}, busy, 1'b0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int first_rd_cyc;
        int n_issued;
        logic [DW-1:0] aa;

        reset     = 1'b0;
        wr_valid  = 1'b1;
        rd_valid  = 1'b1;
        wr_addr   = 11'd100;
        wr_data   = DW'(32'h11);
        rd_addr   = 11'd100;
        rsp_ready = 1'b1;
        fork
            run_monitor();
        join_none

        // Reset held with both requesters active: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", {wr_ready, rd_ready, mem_ce0, mem_we0, rsp_valid, busy}, '0);
            next_cycle();
        end

        // Conflict straight out of reset: W,R,W,R,W,R.
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("conflict_wr_ready", wr_ready, (i % 2 == 0));
            check("conflict_rd_ready", rd_ready, (i % 2 == 1));
            check("conflict_we0", mem_we0, (i % 2 == 0));
            if (rd_ready) exp_q.push_back(DW'(32'h11));
            next_cycle();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        wait_drain("conflict");

        // Writes 0..7 with data addr*3, then reads back in order.
        for (int a = 0; a < 8; a++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(a);
            wr_data  = DW'(a * 3);
            @(negedge clk);
            check("write_ready", wr_ready, 1'b1);
            next_cycle();
        end
        wr_valid     = 1'b0;
        first_rd_cyc = -1;
        first_rsp_cyc = -1;
        lat_armed    = 1'b1;
        rd_valid     = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd_addr = AW'(a);
            @(negedge clk);
            check("read_ready", rd_ready, 1'b1);
            if (rd_ready) begin
                exp_q.push_back(DW'(a * 3));
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            next_cycle();
        end
        rd_valid = 1'b0;
        wait_drain("readback");
        check("read_latency", DW'(first_rsp_cyc - first_rd_cyc), DW'(RD_LAT + 1));

        // Backpressure: only DEPTH reads get credits, head holds still.
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        n_issued  = 0;
        rd_addr   = 11'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 6) begin
                check("stall_rd_ready", rd_ready, 1'b0);
                check("stall_rsp_data", rsp_data, DW'(3));
                check("stall_rsp_valid", rsp_valid, 1'b1);
            end
            if (rd_ready) begin
                exp_q.push_back(DW'((1 + n_issued) * 3));
                n_issued++;
            end
            next_cycle();
            rd_addr = AW'(1 + n_issued);
        end
        check("bp_reads_issued", DW'(n_issued), DW'(DEPTH));
        check("bp_busy", busy, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        if (rd_ready) begin
            exp_q.push_back(DW'((1 + n_issued) * 3));
            n_issued++;
        end
        next_cycle();
        rsp_ready = 1'b0;
        rd_addr   = AW'(1 + n_issued);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rd_ready) begin
                exp_q.push_back(DW'((1 + n_issued) * 3));
                n_issued++;
            end
            next_cycle();
            rd_addr = AW'(1 + n_issued);
        end
        check("bp_one_more_read", DW'(n_issued), DW'(DEPTH + 1));
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("backpressure");

        // Read-after-write to the same address on the next cycle.
        aa       = {32{8'hAA}};
        wr_valid = 1'b1;
        wr_addr  = 11'd5;
        wr_data  = aa;
        @(negedge clk);
        check("raw_wr_ready", wr_ready, 1'b1);
        next_cycle();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 11'd5;
        @(negedge clk);
        check("raw_rd_ready", rd_ready, 1'b1);
        if (rd_ready) exp_q.push_back(aa);
        next_cycle();
        rd_valid = 1'b0;
        wait_drain("raw");

        // Mid-flight reset: two reads vanish without a response.
        rd_valid = 1'b1;
        rd_addr  = 11'd6;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("midreset_rd_ready", rd_ready, 1'b1);
            next_cycle();
        end
        rd_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("midreset_rsp_valid_in_reset", rsp_valid, 1'b0);
        check("midreset_busy_in_reset", busy, 1'b0);
        next_cycle();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midreset_rsp_valid_after", rsp_valid, 1'b0);
            check("midreset_busy_after", busy, 1'b0);
            next_cycle();
        end
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        n_issued  = 0;
        rd_addr   = 11'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rd_ready) begin
                exp_q.push_back(DW'(n_issued * 3));
                n_issued++;
            end
            next_cycle();
            rd_addr = AW'(n_issued);
        end
        check("midreset_credits_restored", DW'(n_issued), DW'(DEPTH));
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("midreset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
